// File: rtl/coef_block_scheduler.sv
// coef_block_scheduler: walks 8x8 raster coefficient blocks out of a ping-pong
// buffer in JPEG zigzag order and streams them to the entropy coder, tagging
// each block with its component according to the frame's sampling mode.
module coef_block_scheduler #(
  parameter int unsigned DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [1:0]            mode,
  input  logic [15:0]           mcu_count,
  input  logic [1:0]            bank_ready,
  output logic [1:0]            bank_release,
  output logic [6:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_done,
  output logic [1:0]            out_comp,
  output logic                  dc_reset,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_LAST
  } state_t;

  // Zigzag scan position -> raster index within the 8x8 block.
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t      state_q;
  logic [1:0]  mode_q;
  logic [15:0] mcu_total_q;
  logic [15:0] mcu_q;
  logic [2:0]  blk_q;
  logic [5:0]  k_q;
  logic        ptr_q;

  logic [6:0]  rd_addr_q;
  logic        out_valid_q;
  logic        out_done_q;
  logic [1:0]  out_comp_q;
  logic [1:0]  bank_release_q;
  logic        dc_reset_q;
  logic        busy_q;
  logic        frame_done_q;

  logic [2:0]  blk_len;
  logic        blk_wrap;
  logic        frame_end;
  logic [1:0]  comp_cur;
  logic [5:0]  k_next;

  // Block-in-MCU bookkeeping derived from the latched sampling mode.
  always_comb begin
    blk_len  = 3'd1;
    comp_cur = 2'd0;
    unique case (mode_q)
      2'd1: begin
        blk_len  = 3'd3;
        comp_cur = blk_q[1:0];
      end
      2'd2: begin
        blk_len  = 3'd6;
        if (blk_q == 3'd4)      comp_cur = 2'd1;
        else if (blk_q == 3'd5) comp_cur = 2'd2;
        else                    comp_cur = 2'd0;
      end
      default: begin
        blk_len  = 3'd1;
        comp_cur = 2'd0;
      end
    endcase
    blk_wrap  = (blk_q == blk_len - 3'd1);
    frame_end = blk_wrap && (mcu_q == mcu_total_q - 16'd1);
    k_next    = k_q + 6'd1;
  end

  // Scheduler FSM with all control outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mode_q         <= '0;
      mcu_total_q    <= '0;
      mcu_q          <= '0;
      blk_q          <= '0;
      k_q            <= '0;
      ptr_q          <= 1'b0;
      rd_addr_q      <= '0;
      out_valid_q    <= 1'b0;
      out_done_q     <= 1'b0;
      out_comp_q     <= '0;
      bank_release_q <= '0;
      dc_reset_q     <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      dc_reset_q     <= 1'b0;
      bank_release_q <= '0;
      frame_done_q   <= 1'b0;
      out_done_q     <= 1'b0;
      // Data for an address issued in READ comes back on the following cycle.
      out_valid_q    <= (state_q == S_READ);

      unique case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            mode_q      <= (mode == 2'd3) ? 2'd0 : mode;
            mcu_total_q <= (mcu_count == 16'd0) ? 16'd1 : mcu_count;
            mcu_q       <= '0;
            blk_q       <= '0;
            ptr_q       <= 1'b0;
            dc_reset_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bank_ready[ptr_q] && !hold) begin
            k_q       <= '0;
            rd_addr_q <= {ptr_q, ZIGZAG[0]};
            state_q   <= S_READ;
          end
        end

        S_READ: begin
          out_comp_q <= comp_cur;
          if (k_q == 6'd63) begin
            rd_addr_q      <= '0;
            out_done_q     <= 1'b1;
            bank_release_q <= ptr_q ? 2'b10 : 2'b01;
            frame_done_q   <= frame_end;
            state_q        <= S_LAST;
          end else begin
            k_q       <= k_next;
            rd_addr_q <= {ptr_q, ZIGZAG[k_next]};
          end
        end

        S_LAST: begin
          ptr_q <= ~ptr_q;
          if (blk_wrap) begin
            blk_q <= '0;
            mcu_q <= mcu_q + 16'd1;
          end else begin
            blk_q <= blk_q + 3'd1;
          end
          if (frame_end) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (bank_ready[~ptr_q] && !hold) begin
            // The next bank is checked here so a ready bank starts READ
            // straight away, leaving a single gap cycle between blocks.
            k_q       <= '0;
            rd_addr_q <= {~ptr_q, ZIGZAG[0]};
            state_q   <= S_READ;
          end else begin
            state_q <= S_WAIT;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Buffer read data is forwarded in its return cycle; zero when not valid.
  assign out_data     = out_valid_q ? rd_data : '0;
  assign rd_addr      = rd_addr_q;
  assign out_valid    = out_valid_q;
  assign out_done     = out_done_q;
  assign out_comp     = out_comp_q;
  assign bank_release = bank_release_q;
  assign dc_reset     = dc_reset_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_coef_block_scheduler.sv
// Testbench for coef_block_scheduler: directed scenarios plus randomized
// frames, checked against a block-list reference model and buffer contents.
module tb_coef_block_scheduler;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic [1:0]    mode;
  logic [15:0]   mcu_count;
  logic [1:0]    bank_ready;
  logic [1:0]    bank_release;
  logic [6:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          hold;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_done;
  logic [1:0]    out_comp;
  logic          dc_reset;
  logic          busy;
  logic          frame_done;

  coef_block_scheduler #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .mode         (mode),
    .mcu_count    (mcu_count),
    .bank_ready   (bank_ready),
    .bank_release (bank_release),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .hold         (hold),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_done     (out_done),
    .out_comp     (out_comp),
    .dc_reset     (dc_reset),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Coefficient buffer: synchronous read, data one cycle after the address.
  logic [DW-1:0] mem [128];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: each accepted frame expands into a list of blocks.
  typedef struct packed {
    logic [1:0] comp;
    logic       bank;
    logic       last;
  } blk_t;

  blk_t       exp_q[$];
  blk_t       mb;
  int         zz[64];
  int         mon_k      = 0;
  bit         mbusy      = 0;
  bit         clear_next = 0;
  bit         pend       = 0;
  logic [1:0] pend_mode;
  int         pend_cnt;
  int         gap        = 0;
  bit         gap_armed  = 0;
  bit         chk_gap_en = 0;
  int         valid_seen = 0;
  int         dc_pulses  = 0;
  int         n_accept   = 0;

  task automatic build_frame(input logic [1:0] m, input int c);
    int n, len, mm, bi;
    blk_t b;
    n   = (c == 0) ? 1 : c;
    mm  = (m == 2'd3) ? 0 : int'(m);
    len = (mm == 2) ? 6 : ((mm == 1) ? 3 : 1);
    for (int i = 0; i < n * len; i++) begin
      bi     = i % len;
      b.bank = 1'(i % 2);
      if (mm == 2)      b.comp = (bi < 4) ? 2'd0 : 2'(bi - 3);
      else if (mm == 1) b.comp = 2'(bi);
      else              b.comp = 2'd0;
      b.last = (i == n * len - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: samples one time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      check("rst_outs", {rd_addr, out_valid, out_done, bank_release, dc_reset,
                         busy, frame_done, out_data, out_comp}, '0);
      exp_q.delete();
      mon_k = 0; mbusy = 0; clear_next = 0; pend = 0; gap_armed = 0;
    end else begin
      if (clear_next) begin mbusy = 0; clear_next = 0; end
      check("dc_reset", dc_reset, pend);
      if (dc_reset) dc_pulses++;
      if (pend) begin
        build_frame(pend_mode, pend_cnt);
        mbusy = 1; pend = 0; gap_armed = 0;
      end
      check("busy", busy, mbusy);
      if (out_valid) begin
        valid_seen++;
        if (exp_q.size() == 0) begin
          check("unexp_valid", 1, 0);
        end else begin
          mb = exp_q[0];
          if (mon_k == 0 && gap_armed && chk_gap_en) check("gap", gap, 1);
          check("data", out_data, mem[int'(mb.bank) * 64 + zz[mon_k]]);
          check("comp", out_comp, mb.comp);
          check("done", out_done, mon_k == 63);
          check("release", bank_release, (mon_k == 63) ? (mb.bank ? 2'b10 : 2'b01) : 2'b00);
          check("frame_done", frame_done, (mon_k == 63) && mb.last);
          if (mon_k == 63) begin
            void'(exp_q.pop_front());
            mon_k = 0; gap = 0; gap_armed = !mb.last;
            if (mb.last) clear_next = 1;
          end else begin
            mon_k++;
          end
        end
      end else begin
        if (mon_k != 0) check("contig", out_valid, 1);
        check("idle_pulses", {out_done, bank_release, frame_done}, 0);
        gap++;
      end
    end
  end

  task automatic start_frame(input logic [1:0] m, input int c);
    @(negedge clk);
    frame_start = 1'b1;
    mode        = m;
    mcu_count   = 16'(c);
    if (!mbusy && !pend) begin
      pend = 1; pend_mode = m; pend_cnt = c; n_accept++;
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int cyc = 0;
    do begin
      @(negedge clk);
      if (rnd) begin
        bank_ready = 2'($urandom);
        hold       = ($urandom_range(0, 3) == 0);
      end
      cyc++;
    end while ((mbusy || pend || exp_q.size() != 0) && cyc < 20000);
    check("idle_timeout", (mbusy || pend || exp_q.size() != 0), 0);
  endtask

  task automatic fill_random();
    logic [31:0] r;
    logic [6:0]  a7;
    for (int a = 0; a < 128; a++) begin
      r      = $urandom;
      a7     = 7'(a);
      mem[a] = {r[2:0], a7};
    end
  endtask

  initial begin
    int k, v0, cyc;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz[k] = r * 8 + (s - r); k++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
          zz[k] = r * 8 + (s - r); k++;
        end
      end
    end
    for (int a = 0; a < 128; a++) mem[a] = DW'(a % 64);

    rst_n = 1'b0; frame_start = 1'b0; mode = '0; mcu_count = '0;
    bank_ready = '0; hold = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Grey, one MCU, raster-index data.
    bank_ready = 2'b01;
    start_frame(2'd0, 1);
    wait_idle(0);

    // 4:2:0, two MCUs, both banks always ready: back-to-back blocks.
    fill_random();
    bank_ready = 2'b11; chk_gap_en = 1;
    start_frame(2'd2, 2);
    wait_idle(0);
    chk_gap_en = 0;

    // Hold through WAIT, then latency after release, then hold mid-block.
    bank_ready = 2'b01; hold = 1'b1;
    start_frame(2'd0, 1);
    v0 = valid_seen;
    repeat (20) @(negedge clk);
    check("hold_wait", valid_seen - v0, 0);
    hold = 1'b0;
    @(posedge clk); #1;
    check("lat_k0", out_valid, 0);
    @(posedge clk); #1;
    check("lat_first", out_valid, 1);
    repeat (20) @(negedge clk);
    hold = 1'b1; bank_ready = 2'b00;
    wait_idle(0);
    hold = 1'b0;

    // Bank 1 not ready after block 0.
    fill_random();
    bank_ready = 2'b01;
    start_frame(2'd1, 1);
    cyc = 0;
    while (exp_q.size() > 2 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("blk0_timeout", exp_q.size() > 2, 0);
    v0 = valid_seen;
    repeat (20) @(negedge clk);
    check("wait_bank1", valid_seen - v0, 0);
    bank_ready = 2'b11;
    @(posedge clk); #1;
    check("resume_bank", rd_addr[6], 1);
    wait_idle(0);

    // Reserved mode, frame_start while busy ignored.
    bank_ready = 2'b11;
    start_frame(2'd3, 2);
    repeat (10) @(negedge clk);
    start_frame(2'd2, 5);
    wait_idle(0);

    // Reset in the middle of a block.
    fill_random();
    start_frame(2'd0, 4);
    cyc = 0;
    while (mon_k != 30 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("k30_timeout", mon_k, 30);
    rst_n = 1'b0;
    #1;
    check("rst_async", {rd_addr, out_valid, out_done, bank_release, dc_reset,
                        busy, frame_done, out_data}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bank_ready = 2'b01;
    start_frame(2'd1, 0);
    bank_ready = 2'b11;
    wait_idle(0);

    // Randomized frames with random back-pressure and bank readiness.
    for (int f = 0; f < 6; f++) begin
      fill_random();
      start_frame(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      wait_idle(1);
    end

    check("dc_count", dc_pulses, n_accept);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/coef_block_scheduler.md
COEF_BLOCK_SCHEDULER -- requirements
Module: coef_block_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, coefficient width in two's complement.
REQ-002 SHALL have clk, input, 1, rising-edge clock.
REQ-003 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have frame_start, input, 1, single-cycle pulse that starts a frame; ignored unless state is IDLE.
REQ-005 SHALL have mode, input, 2, sampling: 0 = grey (Y), 1 = 4:4:4 (Y,Cb,Cr), 2 = 4:2:0 (Y,Y,Y,Y,Cb,Cr), 3 = reserved, treated as 0; sampled at frame_start.
REQ-006 SHALL have mcu_count, input, 16, MCUs per frame, sampled at frame_start; 0 is treated as 1.
REQ-007 SHALL have bank_ready, input, 2, per ping-pong bank level flag: a full 8x8 raster block is present.
REQ-008 SHALL have bank_release, output, 2, one-cycle pulse: bank consumed.
REQ-009 SHALL have rd_addr, output, 7, buffer read address {bank, raster[5:0]}; read data returns one cycle later.
REQ-010 SHALL have rd_data, input, DATA_WIDTH, coefficient read data.
REQ-011 SHALL have hold, input, 1, downstream back-pressure; sampled only at block boundaries.
REQ-012 SHALL have out_data, out_valid, out_done, outputs, DATA_WIDTH/1/1, coefficient stream to the entropy coder.
REQ-013 SHALL have out_comp, output, 2, component of the current block: 0 Y, 1 Cb, 2 Cr.
REQ-014 SHALL have dc_reset, output, 1, one-cycle pulse clearing the DC predictors.
REQ-015 SHALL have busy and frame_done, outputs, 1 each; busy is a level, frame_done is a one-cycle pulse.

Function
REQ-016 SHALL implement states IDLE, WAIT, READ, LAST.
REQ-017 SHALL, in IDLE on frame_start: latch mode and mcu_count, pulse dc_reset the next cycle, clear the MCU and block counters, set the bank pointer to 0, and go to WAIT.
REQ-018 SHALL, in WAIT, enter READ only when bank_ready[ptr]=1 and hold=0.
REQ-019 SHALL, in READ, issue 64 addresses on consecutive cycles, k = 0..63, with rd_addr = {ptr, zigzag(k)} from the standard JPEG zigzag table (k=0 -> 0, k=1 -> 1, k=2 -> 8, k=63 -> 63), then go to LAST.
REQ-020 SHALL present rd_data on out_data with out_valid=1 exactly one cycle after each address, giving 64 contiguous valid cycles with no gaps.
REQ-021 SHALL assert out_done together with out_valid only on the 64th coefficient, in the LAST cycle.
REQ-022 SHALL hold out_comp constant for all 64 valid cycles of a block, taken from the mode sequence indexed by the block-in-MCU counter.
REQ-023 SHALL pulse bank_release[ptr] in the LAST cycle and then toggle ptr.
REQ-024 SHALL advance the counters in the LAST cycle: the block counter wraps at the MCU length (1/3/6) and then increments the MCU counter.
REQ-025 SHALL, after the last block of MCU mcu_count-1: pulse frame_done in the LAST cycle and go to IDLE; otherwise go to WAIT.
REQ-026 SHALL allow back-to-back blocks: if the next bank is ready and hold=0 in the LAST cycle, READ k=0 starts in the next cycle, keeping 64 valid cycles per 65-cycle period.
REQ-027 SHALL ignore hold and bank_ready changes during READ and LAST.
REQ-028 SHALL ignore frame_start while busy.
REQ-029 SHALL drive busy=1 in every state except IDLE.
REQ-030 SHALL set per-block latency, WAIT exit to first out_valid, to 2 cycles.

Reset
REQ-031 SHALL, while rst_n=0, put the block in IDLE and drive ptr=0, all counters 0, and all outputs 0 (rd_addr 0, out_data 0).
REQ-032 SHALL, on reset mid-block, drop the block with no out_done and no bank_release; the next frame restarts at bank 0.

Verification
REQ-033 Bench SHALL cover: mode=0, mcu_count=1, bank0 ready, rd_data=raster index -> 64 valid, out_data sequence 0,1,8,16,9,2...63, out_done on the 64th, bank_release=01, frame_done same cycle.
REQ-034 Bench SHALL cover: mode=2, mcu_count=2, both banks always ready -> 12 blocks, out_comp 0,0,0,0,1,2 repeated, release alternating 01/10, one gap cycle between blocks.
REQ-035 Bench SHALL cover: hold=1 through WAIT -> no address issued; hold drops -> out_valid 2 cycles later; hold raised mid-block -> no effect.
REQ-036 Bench SHALL cover: bank1 not ready after block 0 -> stays in WAIT with out_valid=0; bank_ready[1] rises -> resumes with rd_addr[6]=1.
REQ-037 Bench SHALL cover: frame_start while busy -> ignored; dc_reset pulses once per accepted frame_start; mode=3 behaves as mode=0.
REQ-038 Bench SHALL cover: rst_n low at k=30 -> all outputs 0 immediately, no out_done or release; new frame_start -> reads bank 0.
